alu_req_arbiter: RTL

Two-requester round-robin arbiter and sequencer for the shared 16-bit registered ALU (op_code/a_in/b_in/cin -> y_out/cout, one-clock registered latency).
- Accepts operation requests over valid/ready handshakes and drives the ALU inputs for exactly one issue cycle.
- Captures the ALU result and returns it to the originating requester as a one-cycle response pulse.
- Sits between datapath clients and the ALU instance. At the top level, the ALU's active-low reset_n is driven by ~reset.

---
 rtl/alu_req_arbiter.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/alu_req_arbiter.sv
// Two-requester round-robin arbiter/sequencer in front of the shared registered 16-bit ALU.
// Optional illegal-op short-circuit enabled by defining ALU_ARB_OPCHECK_EN.
module alu_req_arbiter #(
    parameter int DATA_W = 16,
    parameter int OP_W   = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [OP_W-1:0]   req0_op,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,
    input  logic              req0_cin,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [OP_W-1:0]   req1_op,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,
    input  logic              req1_cin,
    output logic [OP_W-1:0]   alu_op,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic              alu_cin,
    input  logic [DATA_W-1:0] alu_y,
    input  logic              alu_cout,
    output logic              rsp0_valid,
    output logic              rsp1_valid,
    output logic [DATA_W-1:0] rsp_y,
    output logic              rsp_cout,
    output logic              rsp_err,
    output logic              busy
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [OP_W-1:0]   op_q, op_d;
    logic [DATA_W-1:0] a_q, a_d, b_q, b_d;
    logic              cin_q, cin_d;
    logic              owner_q, owner_d;
    logic              last_grant_q, last_grant_d;
    logic [DATA_W-1:0] rsp_y_q, rsp_y_d;
    logic              rsp_cout_q, rsp_cout_d;
    logic              rsp_err_q, rsp_err_d;
    logic              grant0_s, grant1_s;

`ifdef ALU_ARB_OPCHECK_EN
    function automatic logic op_illegal(input logic [OP_W-1:0] op);
        return (op == OP_W'(7)) || (op >= OP_W'(12));
    endfunction
`endif

    // State and datapath registers; reset dominates every other input.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            op_q         <= '0;
            a_q          <= '0;
            b_q          <= '0;
            cin_q        <= 1'b0;
            owner_q      <= 1'b0;
            last_grant_q <= 1'b1;
            rsp_y_q      <= '0;
            rsp_cout_q   <= 1'b0;
            rsp_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            a_q          <= a_d;
            b_q          <= b_d;
            cin_q        <= cin_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            rsp_y_q      <= rsp_y_d;
            rsp_cout_q   <= rsp_cout_d;
            rsp_err_q    <= rsp_err_d;
        end
    end

    // Next-state logic: accept a request in IDLE, capture the ALU result in WAIT.
    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        a_d          = a_q;
        b_d          = b_q;
        cin_d        = cin_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        rsp_y_d      = rsp_y_q;
        rsp_cout_d   = rsp_cout_q;
        rsp_err_d    = rsp_err_q;
        case (state_q)
            S_IDLE: begin
                if (req0_ready || req1_ready) begin
                    owner_d      = req1_ready;
                    last_grant_d = req1_ready;
                    op_d         = req1_ready ? req1_op  : req0_op;
                    a_d          = req1_ready ? req1_a   : req0_a;
                    b_d          = req1_ready ? req1_b   : req0_b;
                    cin_d        = req1_ready ? req1_cin : req0_cin;
                    state_d      = S_ISSUE;
`ifdef ALU_ARB_OPCHECK_EN
                    if (op_illegal(op_d)) begin
                        state_d    = S_RESP;
                        rsp_y_d    = '0;
                        rsp_cout_d = 1'b0;
                        rsp_err_d  = 1'b1;
                    end else begin
                        state_d    = S_ISSUE;
                    end
`endif
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ISSUE: state_d = S_WAIT;
            S_WAIT: begin
                state_d    = S_RESP;
                rsp_y_d    = alu_y;
                rsp_cout_d = alu_cout;
                rsp_err_d  = 1'b0;
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs decoded from registered state; ready is the only combinational path from inputs.
    always_comb begin
        grant0_s   = req0_valid && (!req1_valid || last_grant_q);
        grant1_s   = req1_valid && (!req0_valid || !last_grant_q);
        req0_ready = (state_q == S_IDLE) && !reset && grant0_s;
        req1_ready = (state_q == S_IDLE) && !reset && grant1_s;
        alu_op     = (state_q == S_ISSUE) ? op_q : {OP_W{1'b1}};
        alu_a      = a_q;
        alu_b      = b_q;
        alu_cin    = cin_q;
        rsp0_valid = (state_q == S_RESP) && !owner_q;
        rsp1_valid = (state_q == S_RESP) && owner_q;
        rsp_y      = rsp_y_q;
        rsp_cout   = rsp_cout_q;
        rsp_err    = rsp_err_q;
        busy       = (state_q != S_IDLE);
    end

endmodule
